argmax_unit: RTL and testbench
==============================

ARGMAX_UNIT -- requirements
Module: argmax_unit

Interface
REQ-001 Parameter FEATURE_ROWS, default 6, number of node rows to classify.
REQ-002 Parameter WEIGHT_COLS, default 3, number of classes (columns) per row.
REQ-003 Parameter DOT_PROD_WIDTH, default 16, width of each signed score element.
REQ-004 Parameters ROW_W = $clog2(FEATURE_ROWS) and COL_W = $clog2(WEIGHT_COLS), derived, not overridden.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  level request to run one classification pass.
REQ-008 rd_en  output  1  score-memory read strobe.
REQ-009 rd_row  output  ROW_W  row address of current read.
REQ-010 rd_col  output  COL_W  column address of current read.
REQ-011 rd_data  input  DOT_PROD_WIDTH  signed score, valid exactly one cycle after rd_en.
REQ-012 argmax_out  output  FEATURE_ROWS*COL_W  packed winning class index per row; row r at bits [r*COL_W +: COL_W].
REQ-013 wr_en  output  1  one-cycle pulse: a row result was just committed.
REQ-014 wr_row  output  ROW_W  row index qualified by wr_en.
REQ-015 done  output  1  pass complete, all argmax_out fields valid.

Function
REQ-016 FSM states SHALL be IDLE, READ, DRAIN, DONE.
REQ-017 IDLE: rd_en=0, done=0; start=1 -> READ next cycle; else stay.
REQ-018 READ: rd_en=1 every cycle; (rd_row,rd_col) SHALL start at (0,0), col increments each cycle, wraps WEIGHT_COLS-1 -> 0 with row+1.
REQ-019 READ -> DRAIN in the cycle after address (FEATURE_ROWS-1, WEIGHT_COLS-1) is issued; exactly FEATURE_ROWS*WEIGHT_COLS reads per pass, no gaps.
REQ-020 DRAIN: rd_en=0, one cycle to capture final rd_data, then -> DONE.
REQ-021 DONE: done=1; stay while start=1; start=0 -> IDLE (done drops). New pass requires start low then high.
REQ-022 start SHALL be ignored in READ and DRAIN.
REQ-023 Capture pipeline: rd_en, rd_row, rd_col SHALL be registered one stage to qualify rd_data.
REQ-024 Column 0 of a row: running max <= rd_data, running index <= 0.
REQ-025 Column c>0: update max/index only if rd_data > max (signed strict); ties keep lowest index.
REQ-026 On capture of column WEIGHT_COLS-1: argmax_out[row] <= final index (including update from that element) at the same edge.
REQ-027 wr_en SHALL pulse one cycle after that commit edge, with wr_row = committed row; argmax_out[wr_row] already valid.
REQ-028 Latency (start seen in IDLE at cycle 0): reads cycles 1..R*C, last capture cycle R*C+1, done=1 from cycle R*C+2 (20 for defaults), coincident with last wr_en.
REQ-029 Rows of earlier pass SHALL hold in argmax_out until overwritten row-by-row by next pass.
REQ-030 rd_row/rd_col SHALL read 0 outside READ.

Reset
REQ-031 reset asserted, any state: state=IDLE, counters=0, pipeline valid=0, running max/index=0, argmax_out=0, rd_en=0, wr_en=0, wr_row=0, done=0, immediately (asynchronous).
REQ-032 Reset mid-pass SHALL discard partial results; no wr_en after reset deassertion until a new pass.

Verification
REQ-033 Scores row r = {10,20,30} all rows, start held high -> every field=2, 6 wr_en pulses rows 0..5, done rises cycle 20.
REQ-034 Row 0 = {-5,-3,-9} (signed) -> argmax_out[0]=1; row 1 = {-1,-1,-1} -> 0 (tie to lowest).
REQ-035 Row 2 = {7,7,8} -> 2; row 3 = {0x7FFF,0x8000,0} -> 0.
REQ-036 reset pulsed at cycle 8 of pass -> all outputs 0, IDLE; rerun with start -> full correct pass, done at cycle 20 relative to restart.
REQ-037 start toggled during READ -> address sequence unchanged; start held in DONE -> done stays 1; start low -> IDLE, second pass with new scores overwrites all six fields.
REQ-038 Check rd_en high exactly 18 consecutive cycles with addresses (0,0)..(5,2) in order.

Source files
------------

// File: rtl/argmax_unit.sv
// -----------------------------------------------------------------------------
// argmax_unit
//
// Purpose:
//   Reads a FEATURE_ROWS x WEIGHT_COLS matrix of signed scores from an external
//   memory and computes, for every row, the column index holding the largest
//   score. Ties resolve to the lowest column index. Results are packed into
//   argmax_out, one COL_W-bit field per row. Each committed row is announced
//   with a one-cycle wr_en pulse.
//
// Handshake:
//   The score memory has a fixed one-cycle read latency. rd_data is sampled
//   exactly one cycle after rd_en was high. There is no backpressure.
//   start is a level request. It is accepted only in IDLE. A completed pass
//   holds done=1 until start is released, so every new pass needs start to go
//   low and then high again.
//
// Ports:
//   clk        - clock, rising-edge active
//   reset      - asynchronous, active-high reset
//   start      - level request to run one classification pass
//   rd_en      - score-memory read strobe
//   rd_row     - row address of the current read (0 outside READ)
//   rd_col     - column address of the current read (0 outside READ)
//   rd_data    - signed score, valid one cycle after rd_en
//   argmax_out - packed winning index per row, row r at [r*COL_W +: COL_W]
//   wr_en      - one-cycle pulse, row result committed on the previous edge
//   wr_row     - row index qualified by wr_en
//   done       - pass complete, all argmax_out fields valid
// -----------------------------------------------------------------------------
module argmax_unit #(
    parameter int FEATURE_ROWS   = 6,
    parameter int WEIGHT_COLS    = 3,
    parameter int DOT_PROD_WIDTH = 16,
    localparam int ROW_W = $clog2(FEATURE_ROWS),
    localparam int COL_W = $clog2(WEIGHT_COLS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    output logic                            rd_en,
    output logic [ROW_W-1:0]                rd_row,
    output logic [COL_W-1:0]                rd_col,
    input  logic [DOT_PROD_WIDTH-1:0]       rd_data,
    output logic [FEATURE_ROWS*COL_W-1:0]   argmax_out,
    output logic                            wr_en,
    output logic [ROW_W-1:0]                wr_row,
    output logic                            done
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FEATURE_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(WEIGHT_COLS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    // One-stage delay of the read request, so the captured data is tagged with
    // the address it was read from.
    logic                      cap_valid;
    logic [ROW_W-1:0]          cap_row;
    logic [COL_W-1:0]          cap_col;

    // Running maximum of the row currently being captured.
    logic signed [DOT_PROD_WIDTH-1:0] run_max;
    logic [COL_W-1:0]                 run_idx;

    // Running max after folding in the element being captured this cycle.
    logic signed [DOT_PROD_WIDTH-1:0] next_max;
    logic [COL_W-1:0]                 next_idx;

    always_comb begin
        next_max = run_max;
        next_idx = run_idx;
        if (cap_col == '0) begin
            // First column seeds the running max unconditionally.
            next_max = $signed(rd_data);
            next_idx = '0;
        end else if ($signed(rd_data) > run_max) begin
            // Strict compare: an equal later score never displaces the
            // earlier one.
            next_max = $signed(rd_data);
            next_idx = cap_col;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rd_en      <= 1'b0;
            rd_row     <= '0;
            rd_col     <= '0;
            cap_valid  <= 1'b0;
            cap_row    <= '0;
            cap_col    <= '0;
            run_max    <= '0;
            run_idx    <= '0;
            argmax_out <= '0;
            wr_en      <= 1'b0;
            wr_row     <= '0;
            done       <= 1'b0;
        end else begin
            // Capture stage
            cap_valid <= rd_en;
            cap_row   <= rd_row;
            cap_col   <= rd_col;
            wr_en     <= 1'b0;

            if (cap_valid) begin
                run_max <= next_max;
                run_idx <= next_idx;
                if (cap_col == LAST_COL) begin
                    // The field and the wr_en pulse become visible together,
                    // so the field is already valid while wr_en is high.
                    argmax_out[int'(cap_row) * COL_W +: COL_W] <= next_idx;
                    wr_en  <= 1'b1;
                    wr_row <= cap_row;
                end
            end

            // Sequencer
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= READ;
                        rd_en  <= 1'b1;
                        rd_row <= '0;
                        rd_col <= '0;
                    end
                end

                READ: begin
                    if (rd_col == LAST_COL) begin
                        rd_col <= '0;
                        if (rd_row == LAST_ROW) begin
                            // Final address issued; its data arrives in DRAIN.
                            state  <= DRAIN;
                            rd_en  <= 1'b0;
                            rd_row <= '0;
                        end else begin
                            rd_row <= rd_row + 1'b1;
                        end
                    end else begin
                        rd_col <= rd_col + 1'b1;
                    end
                end

                DRAIN: begin
                    state <= DONE;
                    done  <= 1'b1;
                end

                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    rd_en <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_unit.sv
// -----------------------------------------------------------------------------
// tb_argmax_unit
//
// Drives argmax_unit against a one-cycle-latency score memory model. Expected
// read addresses and expected row results are queued when a pass is launched.
// A negedge monitor pops and compares them as the DUT issues reads and wr_en
// pulses, and it tracks the full expected contents of argmax_out.
// -----------------------------------------------------------------------------
module tb_argmax_unit;

    localparam int R  = 6;
    localparam int C  = 3;
    localparam int W  = 16;
    localparam int RW = $clog2(R);
    localparam int CW = $clog2(C);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic               start;
    logic               rd_en;
    logic [RW-1:0]      rd_row;
    logic [CW-1:0]      rd_col;
    logic [W-1:0]       rd_data;
    logic [R*CW-1:0]    argmax_out;
    logic               wr_en;
    logic [RW-1:0]      wr_row;
    logic               done;

    argmax_unit #(
        .FEATURE_ROWS   (R),
        .WEIGHT_COLS    (C),
        .DOT_PROD_WIDTH (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rd_en      (rd_en),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_data    (rd_data),
        .argmax_out (argmax_out),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .done       (done)
    );

    // ---------------- score memory model ----------------
    logic [W-1:0] mem [R][C];

    // Data appears one cycle after the read. Otherwise the bus carries junk,
    // so a capture on the wrong cycle shows up as a wrong result.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_row][rd_col];
        else       rd_data <= W'($urandom);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [RW+CW-1:0] addr_q[$];   // expected {row,col} read sequence
    logic [RW+CW-1:0] exp_q[$];    // expected {row,idx} commits
    logic [R*CW-1:0]  model_out;   // expected argmax_out contents
    int rd_count;
    int rd_rises;
    logic prev_rd;

    function automatic int ref_idx(input int r);
        int best;
        best = 0;
        for (int c = 1; c < C; c++)
            if ($signed(mem[r][c]) > $signed(mem[r][best])) best = c;
        return best;
    endfunction

    function automatic logic [CW-1:0] field(input int r);
        return argmax_out[r*CW +: CW];
    endfunction

    task automatic load_queues();
        addr_q.delete();
        exp_q.delete();
        rd_count = 0;
        rd_rises = 0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) addr_q.push_back({RW'(r), CW'(c)});
            exp_q.push_back({RW'(r), CW'(ref_idx(r))});
        end
    endtask

    always @(negedge clk) begin
        logic [RW+CW-1:0] e;
        if (rd_en) begin
            rd_count++;
            if (!prev_rd) rd_rises++;
            if (addr_q.size() > 0) begin
                e = addr_q.pop_front();
                check("rd_addr", {27'd0, rd_row, rd_col}, {27'd0, e});
            end else begin
                check("rd_unexpected", 32'd1, 32'd0);
            end
        end else begin
            check("idle_addr", {27'd0, rd_row, rd_col}, 32'd0);
        end
        prev_rd = rd_en;

        if (wr_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_row", {29'd0, wr_row}, {29'd0, e[RW+CW-1:CW]});
                model_out[int'(e[RW+CW-1:CW])*CW +: CW] = e[CW-1:0];
            end else begin
                check("wr_unexpected", 32'd1, 32'd0);
            end
        end
        check("argmax_out", {14'd0, argmax_out}, {14'd0, model_out});
    end

    // ---------------- driver tasks ----------------
    task automatic fill_random();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                mem[r][c] = W'($urandom_range(0, 65535));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},  {31'd0, rd_en}, 32'd0);
        check({tag, "_addr"},   {27'd0, rd_row, rd_col}, 32'd0);
        check({tag, "_wr_en"},  {31'd0, wr_en}, 32'd0);
        check({tag, "_wr_row"}, {29'd0, wr_row}, 32'd0);
        check({tag, "_done"},   {31'd0, done}, 32'd0);
        check({tag, "_argmax"}, {14'd0, argmax_out}, 32'd0);
    endtask

    // Launch a pass from IDLE and follow it to DONE and back to IDLE.
    task automatic run_pass(input int exp_done, input bit toggle);
        int cyc;
        load_queues();
        @(negedge clk); #1;
        start = 1'b1;
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (done) break;
            if (toggle && cyc < 16) start = 1'($urandom_range(0, 1));
            else                    start = 1'b1;
        end
        check("done_cycle", cyc, exp_done);
        repeat (3) begin
            @(posedge clk); #1;
            check("done_hold", {31'd0, done}, 32'd1);
        end
        check("rd_count",    rd_count, 18);
        check("rd_runs",     rd_rises, 1);
        check("addr_q_left", addr_q.size(), 0);
        check("exp_q_left",  exp_q.size(), 0);
        start = 1'b0;
        @(posedge clk); #1;
        check("done_drop", {31'd0, done}, 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("idle_rd_en", {31'd0, rd_en}, 32'd0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        model_out = '0;
        prev_rd   = 1'b0;
        rd_count  = 0;
        rd_rises  = 0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Pass 1: identical rows, increasing scores -> every field 2.
        for (int r = 0; r < R; r++) begin
            mem[r][0] = 16'd10; mem[r][1] = 16'd20; mem[r][2] = 16'd30;
        end
        run_pass(20, 1'b0);
        for (int r = 0; r < R; r++) check("pass1_field", {30'd0, field(r)}, 32'd2);

        // Pass 2: signed, tie and extreme-value rows.
        mem[0][0] = 16'hFFFB; mem[0][1] = 16'hFFFD; mem[0][2] = 16'hFFF7;
        mem[1][0] = 16'hFFFF; mem[1][1] = 16'hFFFF; mem[1][2] = 16'hFFFF;
        mem[2][0] = 16'd7;    mem[2][1] = 16'd7;    mem[2][2] = 16'd8;
        mem[3][0] = 16'h7FFF; mem[3][1] = 16'h8000; mem[3][2] = 16'h0000;
        for (int r = 4; r < R; r++)
            for (int c = 0; c < C; c++) mem[r][c] = W'($urandom_range(0, 65535));
        run_pass(20, 1'b0);
        check("row0_negative", {30'd0, field(0)}, 32'd1);
        check("row1_tie",      {30'd0, field(1)}, 32'd0);
        check("row2_last",     {30'd0, field(2)}, 32'd2);
        check("row3_extreme",  {30'd0, field(3)}, 32'd0);

        // Pass 3: reset in cycle 8 of a pass, then a clean rerun.
        fill_random();
        load_queues();
        @(negedge clk); #1;
        start = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        addr_q.delete();
        exp_q.delete();
        model_out = '0;
        start = 1'b0;
        @(negedge clk); #2;
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("post_reset_wr_en", {31'd0, wr_en}, 32'd0);
            check("post_reset_rd_en", {31'd0, rd_en}, 32'd0);
        end
        run_pass(20, 1'b0);

        // Pass 4: start toggled during READ; new scores overwrite every field.
        fill_random();
        run_pass(20, 1'b1);
        for (int r = 0; r < R; r++)
            check("pass4_field", {30'd0, field(r)}, ref_idx(r));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
